// File: rtl/splitter_dest_if.sv
// splitter_dest_if: stream-in / multi-port-out handshake bundle for splitter_dest
//   s_valid, s_ready, s_data, s_dest : upstream beat, its handshake and destination mask
//   m_valid, m_ready, m_data         : per-port handshake and payload, port i at [i*W +: W]
interface splitter_dest_if #(
    parameter int C_NUM_M      = 2,
    parameter int C_DATA_WIDTH = 8
);
    logic                              s_valid;
    logic                              s_ready;
    logic [C_DATA_WIDTH-1:0]           s_data;
    logic [C_NUM_M-1:0]                s_dest;
    logic [C_NUM_M-1:0]                m_valid;
    logic [C_NUM_M-1:0]                m_ready;
    logic [C_NUM_M*C_DATA_WIDTH-1:0]   m_data;
    modport master (output s_valid, s_data, s_dest, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, s_dest, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/splitter_dest.sv
// splitter_dest: fan one valid/ready stream out to the C_NUM_M ports chosen by a per-beat mask
//   clk, reset    : clock, synchronous active-high reset
//   bus           : slave side of splitter_dest_if (s_* upstream beat, m_* output ports)
//   idle_o        : no beat pending or partially delivered
//   drop_count_o  : saturating count of accepted beats whose mask was empty
module splitter_dest #(
    parameter int C_NUM_M      = 2,
    parameter int C_DATA_WIDTH = 8,
    parameter int C_REGISTERED = 0,
    parameter int C_CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    splitter_dest_if.slave         bus,
    output logic                   idle_o,
    output logic [C_CNT_WIDTH-1:0] drop_count_o
);
    logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   drop;
    assign drop = bus.s_valid & bus.s_ready & ~|bus.s_dest;
    assign cnt_d = (drop && !(&cnt_q)) ? cnt_q + C_CNT_WIDTH'(1) : cnt_q;
    assign drop_count_o = cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    generate
        if (C_REGISTERED == 0) begin : g_comb
            // acked marks ports that already took the current beat, so none sees it twice
            logic [C_NUM_M-1:0] acked_q, acked_d;
            assign bus.m_valid = {C_NUM_M{bus.s_valid}} & bus.s_dest & ~acked_q;
            assign bus.m_data  = {C_NUM_M{bus.s_data}};
            assign bus.s_ready = &(bus.m_ready | acked_q | ~bus.s_dest);
            assign acked_d = (bus.s_valid & bus.s_ready) ? '0 : acked_q | (bus.m_valid & bus.m_ready);
            assign idle_o = ~|acked_q;
            always_ff @(posedge clk) begin
                if (reset) acked_q <= '0;
                else       acked_q <= acked_d;
            end
        end else begin : g_reg
            logic [C_NUM_M-1:0]              full_q, full_d, load;
            logic [C_NUM_M*C_DATA_WIDTH-1:0] data_q, data_d;
            // a selected slot may accept if it is empty or drains in the same cycle
            assign bus.s_ready = &(~bus.s_dest | ~full_q | bus.m_ready);
            assign load = {C_NUM_M{bus.s_valid & bus.s_ready}} & bus.s_dest;
            assign full_d = load | (full_q & ~bus.m_ready);
            for (genvar i = 0; i < C_NUM_M; i++) begin : g_port
                assign data_d[i*C_DATA_WIDTH +: C_DATA_WIDTH] =
                    load[i] ? bus.s_data : data_q[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
            assign bus.m_valid = full_q;
            assign bus.m_data  = data_q;
            assign idle_o = ~|full_q;
            always_ff @(posedge clk) begin
                if (reset) full_q <= '0;
                else       full_q <= full_d;
            end
            always_ff @(posedge clk) data_q <= data_d;
        end
    endgenerate
endmodule

// File: tb/tb_splitter_dest.sv
// tb_splitter_dest: table-driven checks of the combinational variant plus hand sequences for the registered one
module tb_splitter_dest;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    splitter_dest_if #(.C_NUM_M(3), .C_DATA_WIDTH(8)) b0 ();
    splitter_dest_if #(.C_NUM_M(2), .C_DATA_WIDTH(8)) b1 ();
    logic       idle0, idle1;
    logic [1:0] cnt0, cnt1;
    splitter_dest #(.C_NUM_M(3), .C_DATA_WIDTH(8), .C_REGISTERED(0), .C_CNT_WIDTH(2)) u0 (
        .clk(clk), .reset(reset), .bus(b0.slave), .idle_o(idle0), .drop_count_o(cnt0));
    splitter_dest #(.C_NUM_M(2), .C_DATA_WIDTH(8), .C_REGISTERED(1), .C_CNT_WIDTH(2)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave), .idle_o(idle1), .drop_count_o(cnt1));
    int errs = 0;
    int checks = 0;
    typedef struct {
        logic       vld;
        logic [2:0] dest;
        logic [7:0] data;
        logic [2:0] mr;
        logic [2:0] ev;
        logic       er;
        logic       ei;
        logic [1:0] ec;
    } vec_t;
    vec_t tv [15];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic d1_step(input logic v, input logic [1:0] dest, input logic [7:0] data, input logic [1:0] mr,
                           input logic [1:0] ev, input logic er, input logic [15:0] ed);
        b1.s_valid = v; b1.s_dest = dest; b1.s_data = data; b1.m_ready = mr;
        @(negedge clk);
        chk("m1_valid", 32'(b1.m_valid), 32'(ev));
        chk("m1_s_ready", 32'(b1.s_ready), 32'(er));
        chk("m1_data", 32'(b1.m_data), 32'(ed));
        nxt();
    endtask
    initial begin
        tv[0]  = '{1'b1, 3'b111, 8'hA5, 3'b001, 3'b111, 1'b0, 1'b1, 2'd0};
        tv[1]  = '{1'b1, 3'b111, 8'hA5, 3'b110, 3'b110, 1'b1, 1'b0, 2'd0};
        tv[2]  = '{1'b0, 3'b000, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 2'd0};
        tv[3]  = '{1'b1, 3'b010, 8'h3C, 3'b000, 3'b010, 1'b0, 1'b1, 2'd0};
        tv[4]  = '{1'b1, 3'b010, 8'h3C, 3'b000, 3'b010, 1'b0, 1'b1, 2'd0};
        tv[5]  = '{1'b1, 3'b010, 8'h3C, 3'b101, 3'b010, 1'b0, 1'b1, 2'd0};
        tv[6]  = '{1'b1, 3'b010, 8'h3C, 3'b000, 3'b010, 1'b0, 1'b1, 2'd0};
        tv[7]  = '{1'b1, 3'b010, 8'h3C, 3'b010, 3'b010, 1'b1, 1'b1, 2'd0};
        tv[8]  = '{1'b0, 3'b000, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 2'd0};
        tv[9]  = '{1'b1, 3'b000, 8'h77, 3'b000, 3'b000, 1'b1, 1'b1, 2'd0};
        tv[10] = '{1'b1, 3'b000, 8'h77, 3'b000, 3'b000, 1'b1, 1'b1, 2'd1};
        tv[11] = '{1'b1, 3'b000, 8'h77, 3'b000, 3'b000, 1'b1, 1'b1, 2'd2};
        tv[12] = '{1'b1, 3'b000, 8'h77, 3'b000, 3'b000, 1'b1, 1'b1, 2'd3};
        tv[13] = '{1'b1, 3'b000, 8'h77, 3'b000, 3'b000, 1'b1, 1'b1, 2'd3};
        tv[14] = '{1'b0, 3'b000, 8'h00, 3'b000, 3'b000, 1'b1, 1'b1, 2'd3};
        b0.s_valid = 1'b0; b0.s_dest = '0; b0.s_data = '0; b0.m_ready = '0;
        b1.s_valid = 1'b0; b1.s_dest = '0; b1.s_data = '0; b1.m_ready = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_idle0", 32'(idle0), 32'd1);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_mv0", 32'(b0.m_valid), 32'd0);
        chk("rst_idle1", 32'(idle1), 32'd1);
        chk("rst_mv1", 32'(b1.m_valid), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        nxt();
        for (int i = 0; i < 15; i++) begin
            b0.s_valid = tv[i].vld; b0.s_dest = tv[i].dest; b0.s_data = tv[i].data; b0.m_ready = tv[i].mr;
            @(negedge clk);
            chk($sformatf("m0_valid[%0d]", i), 32'(b0.m_valid), 32'(tv[i].ev));
            chk($sformatf("m0_s_ready[%0d]", i), 32'(b0.s_ready), 32'(tv[i].er));
            chk($sformatf("m0_idle[%0d]", i), 32'(idle0), 32'(tv[i].ei));
            chk($sformatf("m0_cnt[%0d]", i), 32'(cnt0), 32'(tv[i].ec));
            chk($sformatf("m0_data[%0d]", i), 32'(b0.m_data), 32'({tv[i].data, tv[i].data, tv[i].data}));
            nxt();
        end
        for (int i = 0; i < 2; i++) begin
            b1.s_valid = 1'b1; b1.s_dest = 2'b00; b1.s_data = 8'h99; b1.m_ready = 2'b00;
            @(negedge clk);
            chk("m1_drop_ready", 32'(b1.s_ready), 32'd1);
            chk("m1_drop_mv", 32'(b1.m_valid), 32'd0);
            chk("m1_drop_cnt", 32'(cnt1), 32'(i));
            nxt();
        end
        for (int k = 1; k <= 8; k++) begin
            b1.s_valid = 1'b1; b1.s_dest = 2'b11; b1.s_data = 8'(k); b1.m_ready = 2'b11;
            @(negedge clk);
            chk("m1_stream_ready", 32'(b1.s_ready), 32'd1);
            chk("m1_stream_mv", 32'(b1.m_valid), (k == 1) ? 32'd0 : 32'd3);
            if (k > 1) chk("m1_stream_data", 32'(b1.m_data), 32'({8'(k - 1), 8'(k - 1)}));
            nxt();
        end
        b1.s_valid = 1'b0; b1.s_dest = 2'b00;
        @(negedge clk);
        chk("m1_last_mv", 32'(b1.m_valid), 32'd3);
        chk("m1_last_data", 32'(b1.m_data), 32'h0808);
        chk("m1_cnt_hold", 32'(cnt1), 32'd2);
        nxt();
        @(negedge clk);
        chk("m1_drained_mv", 32'(b1.m_valid), 32'd0);
        chk("m1_drained_idle", 32'(idle1), 32'd1);
        nxt();
        d1_step(1'b1, 2'b10, 8'h10, 2'b01, 2'b00, 1'b1, 16'h0808);
        d1_step(1'b1, 2'b01, 8'h21, 2'b01, 2'b10, 1'b1, 16'h1008);
        d1_step(1'b1, 2'b10, 8'h12, 2'b01, 2'b11, 1'b0, 16'h1021);
        d1_step(1'b1, 2'b10, 8'h12, 2'b01, 2'b10, 1'b0, 16'h1021);
        d1_step(1'b1, 2'b10, 8'h12, 2'b11, 2'b10, 1'b1, 16'h1021);
        b0.s_valid = 1'b1; b0.s_dest = 3'b011; b0.s_data = 8'h55; b0.m_ready = 3'b001;
        b1.s_valid = 1'b0; b1.s_dest = 2'b00; b1.m_ready = 2'b00;
        @(negedge clk);
        chk("m1_stall_mv", 32'(b1.m_valid), 32'd2);
        chk("m1_stall_data", 32'(b1.m_data), 32'h1221);
        chk("m0_pre_mv", 32'(b0.m_valid), 32'd3);
        chk("m0_pre_ready", 32'(b0.s_ready), 32'd0);
        nxt();
        reset = 1'b1; b0.m_ready = 3'b000;
        @(negedge clk);
        chk("m0_part_mv", 32'(b0.m_valid), 32'd2);
        chk("m0_part_idle", 32'(idle0), 32'd0);
        chk("m0_part_cnt", 32'(cnt0), 32'd3);
        chk("m1_part_mv", 32'(b1.m_valid), 32'd2);
        chk("m1_part_idle", 32'(idle1), 32'd0);
        nxt();
        reset = 1'b0;
        @(negedge clk);
        chk("m0_rst_idle", 32'(idle0), 32'd1);
        chk("m0_rst_cnt", 32'(cnt0), 32'd0);
        chk("m0_rst_mv", 32'(b0.m_valid), 32'd3);
        chk("m1_rst_idle", 32'(idle1), 32'd1);
        chk("m1_rst_mv", 32'(b1.m_valid), 32'd0);
        chk("m1_rst_cnt", 32'(cnt1), 32'd0);
        nxt();
        b0.s_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
